// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per cycle.
// Supports signed input, overflow saturation and a leading-zero blanking mask.
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6,
  parameter int SIGNED = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      data_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                overflow_q, overflow_d;
  logic [DIGITS-1:0]   lz_q, lz_d;

  logic [BIN_W-1:0]    mag;
  logic                in_neg;
  logic [SR_W-1:0]     sr_adj;
  logic [BCD_W-1:0]    fin_bcd;
  logic [DIGITS-1:0]   lz_calc;

  assign in_neg = (SIGNED != 0) && data_in[BIN_W-1];
  assign mag    = in_neg ? -data_in : data_in;

  // Add-3 correction on every BCD nibble before the shift; binary part passes through.
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sr_q[BIN_W + 4*gi +: 4];
      assign sr_adj[BIN_W + 4*gi +: 4] = (nib > 4'd4) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign fin_bcd = ovf_q ? {DIGITS{4'h9}} : sr_q[SR_W-1 -: BCD_W];

  // Blank a digit only when it and every digit above it are zero; units never blank.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_calc  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (fin_bcd[4*i +: 4] == 4'd0);
      lz_calc[i] = zero_run;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    overflow_d = overflow_q;
    lz_d       = lz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = {{BCD_W{1'b0}}, mag};
          sign_d  = in_neg;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(BIN_W - 1);
        end
      end
      SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        ovf_d = ovf_q | sr_adj[SR_W-1];
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FINISH: begin
        bcd_d      = fin_bcd;
        overflow_d = ovf_q;
        neg_d      = sign_q;
        lz_d       = lz_calc;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      overflow_q <= 1'b0;
      lz_q       <= LZ_RST;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      overflow_q <= overflow_d;
      lz_q       <= lz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign neg      = neg_q;
  assign overflow = overflow_q;
  assign lz_mask  = lz_q;

endmodule
